// File: rtl/tag_rx_sync_seq.sv
// Purpose : front-panel sync receiver/sequencer; debounces a GPIO sync request, then walks
//           symbol/sample counters through one frame (optionally re-arming for the next).
// Latency : 2-cycle synchroniser + 1 IDLE cycle + SYNC_DEBOUNCE SYNC cycles from the GPIO edge to rx_trig.
// Backpressure: none; the frame runs free once triggered, and sync activity during RUN/DONE is ignored.
//
// Ports:
//   clk, reset (synchronous, active-low)
//   fp_gpio_in  : asynchronous front-panel inputs; SYNC_MASK bits OR-ed into the sync request
//   fp_gpio_out : BUSY_MASK while a frame is running, else 0
//   fp_gpio_ddr : constant BUSY_MASK (output enables)
//   cfg_nsig / cfg_nsymb / cfg_continuous : frame geometry, latched at frame start (0 means 1)
//   cfg_rearm   : pulse to return from DONE to IDLE
//   rx_state    : 0 IDLE, 1 SYNC, 2 RUN, 3 DONE
//   rx_sync_en, rx_trig, rx_valid, symbN, sigN, sync_count, timeout_err : status outputs
//
// Optional feature: define SYNC_TIMEOUT_EN to build the idle-timeout counter behind timeout_err.
// Without it, timeout_err is tied low and no counter exists.

module tag_rx_sync_seq #(
    parameter int                   REG_WIDTH      = 12,
    parameter logic [REG_WIDTH-1:0] SYNC_MASK      = 12'h044,
    parameter logic [REG_WIDTH-1:0] BUSY_MASK      = 12'h001,
    parameter int                   NSYMB_WIDTH    = 16,
    parameter int                   SIG_WIDTH      = 24,
    parameter int                   SYNC_DEBOUNCE  = 4,
    parameter int                   TIMEOUT_CYCLES = 1 << 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_WIDTH-1:0]   fp_gpio_in,
    output logic [REG_WIDTH-1:0]   fp_gpio_out,
    output logic [REG_WIDTH-1:0]   fp_gpio_ddr,
    input  logic [SIG_WIDTH-1:0]   cfg_nsig,
    input  logic [NSYMB_WIDTH-1:0] cfg_nsymb,
    input  logic                   cfg_continuous,
    input  logic                   cfg_rearm,
    output logic [1:0]             rx_state,
    output logic                   rx_sync_en,
    output logic                   rx_trig,
    output logic                   rx_valid,
    output logic [NSYMB_WIDTH-1:0] symbN,
    output logic [SIG_WIDTH-1:0]   sigN,
    output logic [7:0]             sync_count,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int                   DEB_W   = (SYNC_DEBOUNCE < 1) ? 1 : $clog2(SYNC_DEBOUNCE + 1);
    localparam logic [DEB_W-1:0]     DEB_ONE = DEB_W'(1);
    localparam logic [DEB_W-1:0]     DEB_MAX = (SYNC_DEBOUNCE < 1) ? DEB_ONE : DEB_W'(SYNC_DEBOUNCE);
    localparam logic [SIG_WIDTH-1:0]   SIG_ONE  = SIG_WIDTH'(1);
    localparam logic [NSYMB_WIDTH-1:0] SYMB_ONE = NSYMB_WIDTH'(1);

    state_t                 state;
    logic                   sync_meta;
    logic                   sync_s;
    logic [DEB_W-1:0]       deb_cnt;
    logic [SIG_WIDTH-1:0]   nsig_l;
    logic [NSYMB_WIDTH-1:0] nsymb_l;
    logic                   cont_l;

    logic                   sync_raw;
    logic                   go_run;
    logic                   sig_last;
    logic                   symb_last;

    assign sync_raw  = |(fp_gpio_in & SYNC_MASK);
    // The debounce count reaching its target is the single point where a frame starts.
    assign go_run    = (state == ST_SYNC) && (deb_cnt == DEB_MAX);
    assign sig_last  = (sigN == (nsig_l - SIG_ONE));
    assign symb_last = (symbN == (nsymb_l - SYMB_ONE));

    assign rx_state    = state;
    assign fp_gpio_ddr = BUSY_MASK;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            sync_meta   <= 1'b0;
            sync_s      <= 1'b0;
            deb_cnt     <= '0;
            nsig_l      <= SIG_ONE;
            nsymb_l     <= SYMB_ONE;
            cont_l      <= 1'b0;
            sigN        <= '0;
            symbN       <= '0;
            sync_count  <= '0;
            rx_trig     <= 1'b0;
            rx_valid    <= 1'b0;
            rx_sync_en  <= 1'b1;
            fp_gpio_out <= '0;
        end else begin
            sync_meta <= sync_raw;
            sync_s    <= sync_meta;
            rx_trig   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (sync_s) begin
                        state   <= ST_SYNC;
                        deb_cnt <= DEB_ONE;
                    end
                end

                ST_SYNC: begin
                    if (go_run) begin
                        // Frame start: latch geometry (0 treated as 1) and raise the run outputs.
                        state       <= ST_RUN;
                        deb_cnt     <= '0;
                        nsig_l      <= (cfg_nsig  == '0) ? SIG_ONE  : cfg_nsig;
                        nsymb_l     <= (cfg_nsymb == '0) ? SYMB_ONE : cfg_nsymb;
                        cont_l      <= cfg_continuous;
                        sigN        <= '0;
                        symbN       <= '0;
                        rx_trig     <= 1'b1;
                        rx_valid    <= 1'b1;
                        rx_sync_en  <= 1'b0;
                        fp_gpio_out <= BUSY_MASK;
                        if (sync_count != 8'hFF) begin
                            sync_count <= sync_count + 8'd1;
                        end
                    end else if (sync_s) begin
                        deb_cnt <= deb_cnt + DEB_ONE;
                    end else begin
                        state   <= ST_IDLE;
                        deb_cnt <= '0;
                    end
                end

                ST_RUN: begin
                    if (sig_last && symb_last) begin
                        // Last sample: counters hold so DONE shows the final position.
                        state       <= cont_l ? ST_IDLE : ST_DONE;
                        rx_valid    <= 1'b0;
                        rx_sync_en  <= cont_l;
                        fp_gpio_out <= '0;
                    end else if (sig_last) begin
                        sigN  <= '0;
                        symbN <= symbN + SYMB_ONE;
                    end else begin
                        sigN <= sigN + SIG_ONE;
                    end
                end

                ST_DONE: begin
                    if (cfg_rearm) begin
                        state      <= ST_IDLE;
                        rx_sync_en <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SYNC_TIMEOUT_EN
    localparam int            TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

    logic [TO_W-1:0] idle_cnt;

    // Counts IDLE cycles, saturating at the limit; the flag is sticky until the next frame start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != ST_IDLE) begin
                idle_cnt <= '0;
            end else if (idle_cnt != TO_MAX) begin
                idle_cnt <= idle_cnt + TO_ONE;
            end

            if (go_run) begin
                timeout_err <= 1'b0;
            end else if ((state == ST_IDLE) && (idle_cnt == (TO_MAX - TO_ONE))) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_tag_rx_sync_seq.sv
module tb_tag_rx_sync_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] fp_gpio_in = '0;
    logic [11:0] fp_gpio_out;
    logic [11:0] fp_gpio_ddr;
    logic [23:0] cfg_nsig = 24'd4;
    logic [15:0] cfg_nsymb = 16'd2;
    logic        cfg_continuous = 1'b0;
    logic        cfg_rearm = 1'b0;
    logic [1:0]  rx_state;
    logic        rx_sync_en;
    logic        rx_trig;
    logic        rx_valid;
    logic [15:0] symbN;
    logic [23:0] sigN;
    logic [7:0]  sync_count;
    logic        timeout_err;

    always #5 clk = ~clk;

    tag_rx_sync_seq #(
        .REG_WIDTH(12), .SYNC_MASK(12'h044), .BUSY_MASK(12'h001),
        .NSYMB_WIDTH(16), .SIG_WIDTH(24), .SYNC_DEBOUNCE(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset),
        .fp_gpio_in(fp_gpio_in), .fp_gpio_out(fp_gpio_out), .fp_gpio_ddr(fp_gpio_ddr),
        .cfg_nsig(cfg_nsig), .cfg_nsymb(cfg_nsymb), .cfg_continuous(cfg_continuous),
        .cfg_rearm(cfg_rearm), .rx_state(rx_state), .rx_sync_en(rx_sync_en),
        .rx_trig(rx_trig), .rx_valid(rx_valid), .symbN(symbN), .sigN(sigN),
        .sync_count(sync_count), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic [15:0] symb;
        logic [23:0] sig;
        logic        trig;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Scoreboard: every rx_valid cycle must match the next expected (symbN, sigN, rx_trig).
    always @(negedge clk) begin
        if (mon_en) begin
            if (rx_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL mon_unexpected_valid got symbN=%0d sigN=%0d trig=%b, expected no output",
                             symbN, sigN, rx_trig);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({symbN, sigN, rx_trig} !== {e.symb, e.sig, e.trig}) begin
                        errors++;
                        $display("FAIL mon_sample got symbN=%0d sigN=%0d trig=%b, expected symbN=%0d sigN=%0d trig=%b",
                                 symbN, sigN, rx_trig, e.symb, e.sig, e.trig);
                    end
                end
            end else begin
                checks++;
                if (rx_trig !== 1'b0) begin
                    errors++;
                    $display("FAIL mon_trig_without_valid got trig=%b valid=%b, expected trig=0", rx_trig, rx_valid);
                end
            end
        end
    end

    task automatic push_frame(input int nsig, input int nsymb);
        for (int s = 0; s < nsymb; s++) begin
            for (int g = 0; g < nsig; g++) begin
                exp_t e;
                e.symb = 16'(s);
                e.sig  = 24'(g);
                e.trig = (s == 0) && (g == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_reset;
        fp_gpio_in = '0;
        cfg_rearm  = 1'b0;
        reset      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        fp_gpio_in = '0;
        reset      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rx_state, rx_sync_en, rx_valid, rx_trig} !== {2'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl got state=%0d sync_en=%b valid=%b trig=%b, expected 0 1 0 0",
                     rx_state, rx_sync_en, rx_valid, rx_trig);
        end
        checks++;
        if ({symbN, sigN, sync_count, timeout_err} !== {16'd0, 24'd0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_counters got symbN=%0d sigN=%0d sync_count=%0d tmo=%b, expected all 0",
                     symbN, sigN, sync_count, timeout_err);
        end
        checks++;
        if ({fp_gpio_out, fp_gpio_ddr} !== {12'h000, 12'h001}) begin
            errors++;
            $display("FAIL reset_gpio got out=%h ddr=%h, expected out=000 ddr=001", fp_gpio_out, fp_gpio_ddr);
        end
        reset  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_short_sync;
        bit saw_sync = 1'b0;
        bit saw_trig = 1'b0;
        fp_gpio_in = 12'h040;
        repeat (3) @(negedge clk);
        fp_gpio_in = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rx_state == 2'd1) saw_sync = 1'b1;
            if (rx_trig === 1'b1) saw_trig = 1'b1;
        end
        checks++;
        if ({saw_sync, saw_trig} !== 2'b10) begin
            errors++;
            $display("FAIL short_sync_path got saw_sync=%b saw_trig=%b, expected 1 0", saw_sync, saw_trig);
        end
        checks++;
        if ({rx_state, sync_count} !== {2'd0, 8'd0}) begin
            errors++;
            $display("FAIL short_sync_end got state=%0d sync_count=%0d, expected 0 0", rx_state, sync_count);
        end
    endtask

    task automatic test_single_frame;
        int n_sync = 0;
        bit done   = 1'b0;
        cfg_nsig = 24'd4; cfg_nsymb = 16'd2; cfg_continuous = 1'b0;
        push_frame(4, 2);
        fp_gpio_in = 12'h004;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (rx_state == 2'd1) n_sync++;
            if (rx_state == 2'd2) cfg_nsig = 24'd7;   // must not affect the running frame
            if (rx_state == 2'd3) done = 1'b1;
        end
        fp_gpio_in = '0;
        cfg_nsig   = 24'd4;
        checks++;
        if ({done, 8'(n_sync), sync_count} !== {1'b1, 8'd4, 8'd1}) begin
            errors++;
            $display("FAIL frame_done got done=%b sync_cycles=%0d sync_count=%0d, expected 1 4 1",
                     done, n_sync, sync_count);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame_samples got %0d samples missing, expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_state, symbN, sigN, fp_gpio_out} !== {2'd3, 16'd1, 24'd3, 12'h000}) begin
            errors++;
            $display("FAIL done_hold got state=%0d symbN=%0d sigN=%0d gpio=%h, expected 3 1 3 000",
                     rx_state, symbN, sigN, fp_gpio_out);
        end
        cfg_rearm = 1'b1;
        @(negedge clk);
        cfg_rearm = 1'b0;
        checks++;
        if ({rx_state, rx_sync_en} !== {2'd0, 1'b1}) begin
            errors++;
            $display("FAIL rearm got state=%0d sync_en=%b, expected 0 1", rx_state, rx_sync_en);
        end
    endtask

    task automatic test_continuous;
        int run   = 0;
        int ntrig = 0;
        bit idle_seen = 1'b0;
        do_reset();
        cfg_nsig = 24'd2; cfg_nsymb = 16'd2; cfg_continuous = 1'b1;
        for (int k = 0; k < 3; k++) push_frame(2, 2);
        fp_gpio_in = 12'h044;
        for (int i = 0; i < 150 && !idle_seen; i++) begin
            @(negedge clk);
            if (rx_state == 2'd1) begin
                run++;
            end else if (rx_trig === 1'b1) begin
                ntrig++;
                checks++;
                if ({8'(run), sync_count} !== {8'd4, 8'(ntrig)}) begin
                    errors++;
                    $display("FAIL cont_trig%0d got sync_cycles=%0d sync_count=%0d, expected 4 %0d",
                             ntrig, run, sync_count, ntrig);
                end
                run = 0;
                if (ntrig == 3) fp_gpio_in = '0;
            end else if (rx_state == 2'd0) begin
                run = 0;
                if (ntrig == 3) idle_seen = 1'b1;
            end
        end
        repeat (6) @(negedge clk);
        checks++;
        if ({8'(ntrig), rx_state, sync_count, 8'(exp_q.size())} !== {8'd3, 2'd0, 8'd3, 8'd0}) begin
            errors++;
            $display("FAIL cont_end got trigs=%0d state=%0d sync_count=%0d pending=%0d, expected 3 0 3 0",
                     ntrig, rx_state, sync_count, exp_q.size());
        end
        cfg_continuous = 1'b0;
    endtask

    task automatic test_reset_midframe;
        bit hit = 1'b0;
        do_reset();
        cfg_nsig = 24'd8; cfg_nsymb = 16'd2; cfg_continuous = 1'b0;
        for (int g = 0; g < 6; g++) begin
            exp_t e;
            e.symb = 16'd0; e.sig = 24'(g); e.trig = (g == 0);
            exp_q.push_back(e);
        end
        fp_gpio_in = 12'h004;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (rx_state == 2'd2 && sigN == 24'd5) hit = 1'b1;
        end
        fp_gpio_in = '0;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({hit, rx_state, sigN, symbN, rx_valid, sync_count, fp_gpio_out} !==
            {1'b1, 2'd0, 24'd0, 16'd0, 1'b0, 8'd0, 12'h000}) begin
            errors++;
            $display("FAIL mid_reset got hit=%b state=%0d sigN=%0d symbN=%0d valid=%b sync_count=%0d gpio=%h, expected 1 0 0 0 0 0 000",
                     hit, rx_state, sigN, symbN, rx_valid, sync_count, fp_gpio_out);
        end
        reset = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_samples got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_zero_cfg;
        int  nrun = 0;
        bit  done = 1'b0;
        do_reset();
        cfg_nsig = 24'd0; cfg_nsymb = 16'd0; cfg_continuous = 1'b0;
        push_frame(1, 1);
        fp_gpio_in = 12'h004;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (rx_state == 2'd2) nrun++;
            if (rx_state == 2'd3) done = 1'b1;
        end
        fp_gpio_in = '0;
        checks++;
        if ({done, 8'(nrun), sync_count, 8'(exp_q.size())} !== {1'b1, 8'd1, 8'd1, 8'd0}) begin
            errors++;
            $display("FAIL zero_cfg got done=%b run_cycles=%0d sync_count=%0d pending=%0d, expected 1 1 1 0",
                     done, nrun, sync_count, exp_q.size());
        end
        cfg_rearm = 1'b1;
        @(negedge clk);
        cfg_rearm = 1'b0;
        checks++;
        if (rx_state !== 2'd0) begin
            errors++;
            $display("FAIL zero_cfg_rearm got state=%0d, expected 0", rx_state);
        end
    endtask

    task automatic test_timeout;
`ifdef SYNC_TIMEOUT_EN
        int n = 0;
        bit trig_seen = 1'b0;
        do_reset();
        do begin
            @(negedge clk);
            n++;
        end while (timeout_err !== 1'b1 && n < 40);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL timeout_set got idle_cycles=%0d, expected 16", n);
        end
        cfg_nsig = 24'd0; cfg_nsymb = 16'd0;
        push_frame(1, 1);
        fp_gpio_in = 12'h004;
        for (int i = 0; i < 40 && !trig_seen; i++) begin
            @(negedge clk);
            if (rx_trig === 1'b1) trig_seen = 1'b1;
        end
        fp_gpio_in = '0;
        checks++;
        if ({trig_seen, timeout_err} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_clear got trig=%b tmo=%b, expected 1 0", trig_seen, timeout_err);
        end
`else
        do_reset();
        repeat (40) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_off got tmo=%b, expected 0", timeout_err);
        end
`endif
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_short_sync();
        test_single_frame();
        test_continuous();
        test_reset_midframe();
        test_zero_cfg();
        test_timeout();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue got %0d pending, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tag_rx_sync_seq.md
TAG_RX_SYNC_SEQ -- requirements
Module: tag_rx_sync_seq

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 12, front-panel GPIO width.
REQ-002 SHALL have parameter SYNC_MASK, default 12'h044, GPIO input bits OR-ed to form the sync request.
REQ-003 SHALL have parameter BUSY_MASK, default 12'h001, GPIO output bits driven while sequencing.
REQ-004 SHALL have parameter NSYMB_WIDTH, default 16, symbol counter width.
REQ-005 SHALL have parameter SIG_WIDTH, default 24, sample-in-symbol counter width.
REQ-006 SHALL have parameter SYNC_DEBOUNCE, default 4, consecutive synchronised-high cycles needed to accept sync (≥1).
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 2^20, idle cycles before timeout flag.
REQ-008 Ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-low.
- fp_gpio_in, in, REG_WIDTH: front-panel inputs, asynchronous.
- fp_gpio_out, out, REG_WIDTH: BUSY_MASK bits high in RUN, else 0.
- fp_gpio_ddr, out, REG_WIDTH: constant BUSY_MASK.
- cfg_nsig, in, SIG_WIDTH: samples per symbol.
- cfg_nsymb, in, NSYMB_WIDTH: symbols per frame.
- cfg_continuous, in, 1: 1 = re-arm after frame.
- cfg_rearm, in, 1: pulse; DONE -> IDLE.
- rx_state, out, 2: 0 IDLE, 1 SYNC, 2 RUN, 3 DONE.
- rx_sync_en, out, 1: high in IDLE/SYNC.
- rx_trig, out, 1: one-cycle frame-start pulse.
- rx_valid, out, 1: high every RUN cycle.
- symbN, out, NSYMB_WIDTH: current symbol index.
- sigN, out, SIG_WIDTH: current sample index.
- sync_count, out, 8: accepted syncs, saturating at 255.
- timeout_err, out, 1: sticky idle-timeout flag.

Function
REQ-009 sync_raw = |(fp_gpio_in & SYNC_MASK) SHALL pass a 2-flop synchroniser; only the synchronised value (sync_s) is used.
REQ-010 IDLE: sync_s=1 -> SYNC with debounce count 1.
REQ-011 SYNC: count increments while sync_s=1; sync_s=0 before count reaches SYNC_DEBOUNCE -> IDLE, count cleared.
REQ-012 Count reaching SYNC_DEBOUNCE -> RUN next cycle, with rx_trig=1 for exactly that first RUN cycle; sigN=0, symbN=0, sync_count +1.
REQ-013 cfg_nsig, cfg_nsymb, cfg_continuous SHALL be latched on the SYNC->RUN transition; changes during RUN ignored.
REQ-014 A latched value of 0 for cfg_nsig or cfg_nsymb SHALL be treated as 1.
REQ-015 RUN: sigN +1 per cycle; at nsig-1 wraps to 0 and symbN +1.
REQ-016 RUN cycle with symbN=nsymb-1 and sigN=nsig-1 is the last; next state IDLE if continuous else DONE; frame length exactly nsig*nsymb rx_valid cycles.
REQ-017 sync_s activity during RUN or DONE SHALL be ignored; continuous re-arm requires sync_s low-to-high through the full debounce again (a still-high sync_s at IDLE entry is accepted via REQ-010).
REQ-018 DONE: symbN/sigN hold last values; cfg_rearm=1 -> IDLE; cfg_rearm in other states ignored.
REQ-019 All outputs SHALL be registered; rx_valid, rx_sync_en, fp_gpio_out decoded from registered state.

Reset
REQ-020 reset=0 at a clk edge SHALL force IDLE, sigN=0, symbN=0, sync_count=0, timeout_err=0, rx_trig=0, rx_valid=0, rx_sync_en=1, fp_gpio_out=0, synchroniser and debounce cleared, from any state including mid-frame.
REQ-021 rx_state SHALL read 0 and fp_gpio_ddr SHALL equal BUSY_MASK during and after reset.

Configuration
REQ-022 With SYNC_TIMEOUT_EN defined, an idle counter SHALL count cycles in IDLE (cleared on leaving IDLE), set timeout_err when reaching TIMEOUT_CYCLES, and clear timeout_err on rx_trig.
REQ-023 Without SYNC_TIMEOUT_EN, timeout_err SHALL be constant 0 and no idle counter exists.

Verification
REQ-024 SYNC_DEBOUNCE=4, nsig=4, nsymb=2, continuous=0; fp_gpio_in=12'h004 held -> rx_trig once, 8 rx_valid cycles, (symbN,sigN) 0,0..0,3,1,0..1,3, then rx_state=3, sync_count=1.
REQ-025 fp_gpio_in=12'h040 for 3 synchronised cycles, then 0 -> SYNC then IDLE, no rx_trig, sync_count=0.
REQ-026 continuous=1, sync held high -> back-to-back frames each preceded by 4 SYNC cycles, sync_count 1,2,3...
REQ-027 reset=0 at RUN sample 5 -> next cycle rx_state=0, sigN=0, symbN=0, rx_valid=0, sync_count=0.
REQ-028 cfg_nsig=0, cfg_nsymb=0 -> single-cycle frame: rx_trig and rx_valid together, then DONE; cfg_rearm -> IDLE.
REQ-029 SYNC_TIMEOUT_EN, TIMEOUT_CYCLES=16, no sync -> timeout_err=1 after 16 IDLE cycles; subsequent sync -> cleared on rx_trig.
